// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream multiplexer and its arbiter.
package stream_mux_pkg;

    typedef enum logic {
        MUX_FIXED = 1'b0,
        MUX_RR    = 1'b1
    } mux_mode_e;

    // Channel index width; never narrower than one bit.
    function automatic int chan_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin grant selection.
// While locked, the held channel keeps the grant. Otherwise the search
// starts at the channel after ptr.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N      = 3,
    localparam int CHAN_W = chan_w(N)
) (
    input  logic [N-1:0]      req,
    input  logic [CHAN_W-1:0] ptr,
    input  logic              lock,
    input  logic [CHAN_W-1:0] held,
    output logic [CHAN_W-1:0] grant,
    output logic              grant_valid
);

    logic [CHAN_W-1:0] idx;

    // The search runs from farthest to nearest, so the nearest requester after ptr is written last and wins.
    always_comb begin
        grant       = held;
        grant_valid = 1'b0;
        idx         = '0;
        if (lock) begin
            grant       = held;
            grant_valid = 1'b1;
        end else begin
            for (int k = N; k >= 1; k--) begin
                idx = CHAN_W'((int'(ptr) + k) % N);
                if (req[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer.
// It has a registered output stage and burst locking. The grant comes
// either from sel (fixed mode) or from round-robin arbitration.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int        WIDTH  = 32,
    parameter  int        N      = 3,
    parameter  mux_mode_e MODE   = MUX_FIXED,
    localparam int        CHAN_W = chan_w(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    input  logic [CHAN_W-1:0]    sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [CHAN_W-1:0]    out_chan,
    input  logic                 out_ready
);

    logic [CHAN_W-1:0] grant;
    logic              grant_valid;
    logic [CHAN_W-1:0] held_chan;
    logic              lock;
    logic              stage_free;
    logic              take;
    logic [WIDTH-1:0]  grant_data;
    logic              grant_last;

    assign stage_free = !out_valid || out_ready;

    generate
        if (MODE == MUX_RR) begin : g_rr
            logic [CHAN_W-1:0] ptr;
            logic              unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .req         (in_valid),
                .ptr         (ptr),
                .lock        (lock),
                .held        (held_chan),
                .grant       (grant),
                .grant_valid (grant_valid)
            );

            // The pointer follows the last accepted channel; the reset value makes channel 0 the first grant.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ptr <= CHAN_W'(N - 1);
                end else if (take) begin
                    ptr <= grant;
                end
            end
        end else begin : g_fixed
            // An out-of-range sel gives no grant. A locked burst ignores sel.
            always_comb begin
                grant       = sel;
                grant_valid = int'(sel) < N;
                if (lock) begin
                    grant       = held_chan;
                    grant_valid = 1'b1;
                end
            end
        end
    endgenerate

    // Only the granted channel sees ready. Its payload is steered toward the output stage.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_valid && (grant == CHAN_W'(i))) begin
                in_ready[i] = stage_free && !rst;
                grant_data  = in_data[i*WIDTH +: WIDTH];
                grant_last  = in_last[i];
            end
        end
    end

    assign take = |(in_valid & in_ready);

    // An accepted non-last beat locks the grant until the burst's last beat is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock      <= 1'b0;
            held_chan <= '0;
        end else if (take) begin
            lock      <= !grant_last;
            held_chan <= grant;
        end
    end

    // Output register: load on accept, clear valid on drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_last  <= grant_last;
            out_chan  <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Testbench for stream_mux: one fixed-mode and one round-robin instance.
// Scoreboard queues are filled as beats are offered and drained as the outputs transfer.
module tb_stream_mux;
    import stream_mux_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  chan;
    } beat_t;

    logic        clk;
    logic        rst;

    logic [95:0] f_in_data;
    logic [2:0]  f_in_valid, f_in_last, f_in_ready;
    logic [1:0]  f_sel, f_out_chan;
    logic [31:0] f_out_data;
    logic        f_out_valid, f_out_last, f_out_ready;

    logic [95:0] r_in_data;
    logic [2:0]  r_in_valid, r_in_last, r_in_ready;
    logic [1:0]  r_sel, r_out_chan;
    logic [31:0] r_out_data;
    logic        r_out_valid, r_out_last, r_out_ready;

    beat_t fq[$];
    beat_t rq[$];
    int    passed = 0;
    int    total  = 0;
    int    rr_ptr = 2;

    stream_mux #(.WIDTH(32), .N(3), .MODE(MUX_FIXED)) u_fix (
        .clk(clk), .rst(rst), .in_data(f_in_data), .in_valid(f_in_valid),
        .in_last(f_in_last), .in_ready(f_in_ready), .sel(f_sel),
        .out_data(f_out_data), .out_valid(f_out_valid), .out_last(f_out_last),
        .out_chan(f_out_chan), .out_ready(f_out_ready)
    );

    stream_mux #(.WIDTH(32), .N(3), .MODE(MUX_RR)) u_rr (
        .clk(clk), .rst(rst), .in_data(r_in_data), .in_valid(r_in_valid),
        .in_last(r_in_last), .in_ready(r_in_ready), .sel(r_sel),
        .out_data(r_out_data), .out_valid(r_out_valid), .out_last(r_out_last),
        .out_chan(r_out_chan), .out_ready(r_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round-robin pick: the first valid channel after p.
    function automatic int rr_pick(input logic [2:0] v, input int p);
        int         g;
        logic [2:0] t;
        g = -1;
        for (int k = 3; k >= 1; k--) begin
            t = v >> ((p + k) % 3);
            if (t[0]) g = (p + k) % 3;
        end
        return g;
    endfunction

    // Scoreboard consumer. It samples mid-cycle, so a beat that is valid and ready here transfers at the next edge.
    always begin
        beat_t got, exp;
        @(negedge clk);
        #2;
        if (f_out_valid && f_out_ready) begin
            got = '{data: f_out_data, last: f_out_last, chan: f_out_chan};
            total++;
            if (fq.size() == 0) begin
                $display("FAIL fix_unexpected_beat got=%h", got);
            end else begin
                exp = fq.pop_front();
                if (got !== exp) $display("FAIL fix_beat got=%h exp=%h", got, exp);
                else passed++;
            end
        end
        if (r_out_valid && r_out_ready) begin
            got = '{data: r_out_data, last: r_out_last, chan: r_out_chan};
            total++;
            if (rq.size() == 0) begin
                $display("FAIL rr_unexpected_beat got=%h", got);
            end else begin
                exp = rq.pop_front();
                if (got !== exp) $display("FAIL rr_beat got=%h exp=%h", got, exp);
                else passed++;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        f_in_data = '0; f_in_valid = '0; f_in_last = '0; f_sel = '0; f_out_ready = 1'b1;
        r_in_data = '0; r_in_valid = '0; r_in_last = '0; r_sel = '0; r_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        f_in_valid = 3'b111;
        r_in_valid = 3'b111;
        #1;
        total++; if (f_in_ready !== 3'b000) $display("FAIL rst_fix_in_ready got=%b exp=000", f_in_ready); else passed++;
        total++; if (r_in_ready !== 3'b000) $display("FAIL rst_rr_in_ready got=%b exp=000", r_in_ready); else passed++;
        total++;
        if ({f_out_valid, f_out_data, f_out_last, f_out_chan} !== '0)
            $display("FAIL rst_fix_outputs got v=%b d=%h l=%b c=%0d exp all 0", f_out_valid, f_out_data, f_out_last, f_out_chan);
        else passed++;
        total++;
        if ({r_out_valid, r_out_data, r_out_last, r_out_chan} !== '0)
            $display("FAIL rst_rr_outputs got v=%b d=%h l=%b c=%0d exp all 0", r_out_valid, r_out_data, r_out_last, r_out_chan);
        else passed++;
        @(negedge clk);
        f_in_valid = '0;
        r_in_valid = '0;
        rst = 1'b0;
        rr_ptr = 2;
    endtask

    task automatic test_fixed_single;
        @(negedge clk);
        f_sel = 2'd1;
        f_in_data[32 +: 32] = 32'hA5A5_0001;
        f_in_last = 3'b111;
        f_in_valid = 3'b010;
        f_out_ready = 1'b1;
        fq.push_back('{data: 32'hA5A5_0001, last: 1'b1, chan: 2'd1});
        #1;
        total++; if (f_in_ready !== 3'b010) $display("FAIL fix_single_ready got=%b exp=010", f_in_ready); else passed++;
        @(negedge clk);
        f_in_valid = '0;
        #1;
        total++; if (f_out_valid !== 1'b1) $display("FAIL fix_single_latency got=%b exp=1", f_out_valid); else passed++;
        @(negedge clk);
        #1;
        total++; if (f_out_valid !== 1'b0) $display("FAIL fix_single_drain got=%b exp=0", f_out_valid); else passed++;
    endtask

    task automatic test_fixed_bad_sel;
        @(negedge clk);
        f_sel = 2'd3;
        f_in_valid = 3'b111;
        #1;
        total++; if (f_in_ready !== 3'b000) $display("FAIL fix_badsel_ready got=%b exp=000", f_in_ready); else passed++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            total++; if (f_out_valid !== 1'b0) $display("FAIL fix_badsel_valid cyc=%0d got=%b exp=0", k, f_out_valid); else passed++;
        end
        @(negedge clk);
        f_in_valid = '0;
        f_sel = 2'd0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        f_sel = 2'd0;
        f_in_data[0 +: 32] = 32'h0000_1234;
        f_in_last = 3'b111;
        f_in_valid = 3'b001;
        f_out_ready = 1'b0;
        fq.push_back('{data: 32'h0000_1234, last: 1'b1, chan: 2'd0});
        #1;
        total++; if (f_in_ready !== 3'b001) $display("FAIL bp_first_ready got=%b exp=001", f_in_ready); else passed++;
        @(negedge clk);
        f_in_data[0 +: 32] = 32'h0000_5678;
        fq.push_back('{data: 32'h0000_5678, last: 1'b1, chan: 2'd0});
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (f_out_valid !== 1'b1 || f_out_data !== 32'h0000_1234 || f_in_ready !== 3'b000)
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h r=%b exp v=1 d=00001234 r=000", k, f_out_valid, f_out_data, f_in_ready);
            else passed++;
            @(negedge clk);
        end
        f_out_ready = 1'b1;
        #1;
        total++; if (f_in_ready !== 3'b001) $display("FAIL bp_release_ready got=%b exp=001", f_in_ready); else passed++;
        @(negedge clk);
        f_in_valid = '0;
        #1;
        total++;
        if (f_out_valid !== 1'b1 || f_out_data !== 32'h0000_5678)
            $display("FAIL bp_no_bubble got v=%b d=%h exp v=1 d=00005678", f_out_valid, f_out_data);
        else passed++;
        @(negedge clk);
        #1;
        total++; if (f_out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", f_out_valid); else passed++;
    endtask

    task automatic test_rr_rotation;
        int g;
        @(negedge clk);
        r_in_data = {32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        r_in_last = 3'b111;
        r_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            r_in_valid = 3'b111;
            g = rr_pick(r_in_valid, rr_ptr);
            rq.push_back('{data: 32'hC0DE_0000 | 32'(g), last: 1'b1, chan: 2'(g)});
            #1;
            total++; if (r_in_ready !== (3'b001 << g)) $display("FAIL rr_rot_ready beat=%0d got=%b exp_chan=%0d", k, r_in_ready, g); else passed++;
            rr_ptr = g;
            @(negedge clk);
        end
        r_in_valid = '0;
        @(negedge clk);
        #1;
        total++; if (r_out_valid !== 1'b0) $display("FAIL rr_rot_drain got=%b exp=0", r_out_valid); else passed++;
    endtask

    task automatic test_rr_burst;
        logic [2:0]  t_valid[5] = '{3'b101, 3'b101, 3'b001, 3'b101, 3'b001};
        logic [31:0] t_data2[5] = '{32'h2000_0000, 32'h2000_0001, 32'h2000_0001, 32'h2000_0002, 32'h2000_0002};
        logic        t_last2[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  t_ready[5] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
        logic        t_oval[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        r_in_data[0 +: 32] = 32'h0000_00AA;
        r_in_last[0] = 1'b1;
        r_out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            r_in_valid = t_valid[k];
            r_in_data[64 +: 32] = t_data2[k];
            r_in_last[2] = t_last2[k];
            if (t_valid[k][2])
                rq.push_back('{data: t_data2[k], last: t_last2[k], chan: 2'd2});
            else if (t_ready[k][0])
                rq.push_back('{data: 32'h0000_00AA, last: 1'b1, chan: 2'd0});
            #1;
            total++; if (r_in_ready !== t_ready[k]) $display("FAIL rr_burst_ready step=%0d got=%b exp=%b", k, r_in_ready, t_ready[k]); else passed++;
            total++; if (r_out_valid !== t_oval[k]) $display("FAIL rr_burst_valid step=%0d got=%b exp=%b", k, r_out_valid, t_oval[k]); else passed++;
            @(negedge clk);
        end
        rr_ptr = 0;
        r_in_valid = '0;
        @(negedge clk);
        #1;
        total++; if (r_out_valid !== 1'b0) $display("FAIL rr_burst_drain got=%b exp=0", r_out_valid); else passed++;
    endtask

    task automatic test_reset_mid_burst;
        int g;
        @(negedge clk);
        r_in_data[32 +: 32] = 32'h3000_0000;
        r_in_last = 3'b000;
        r_in_valid = 3'b010;
        r_out_ready = 1'b1;
        g = rr_pick(r_in_valid, rr_ptr);
        rq.push_back('{data: 32'h3000_0000, last: 1'b0, chan: 2'(g)});
        #1;
        total++; if (r_in_ready !== 3'b010) $display("FAIL rst_burst_ready1 got=%b exp=010", r_in_ready); else passed++;
        @(negedge clk);
        r_in_data[32 +: 32] = 32'h3000_0001;
        #1;
        total++; if (r_in_ready !== 3'b010) $display("FAIL rst_burst_ready2 got=%b exp=010", r_in_ready); else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({r_out_valid, r_out_data, r_out_last, r_out_chan} !== '0)
            $display("FAIL rst_burst_outputs got v=%b d=%h l=%b c=%0d exp all 0", r_out_valid, r_out_data, r_out_last, r_out_chan);
        else passed++;
        total++; if (r_in_ready !== 3'b000) $display("FAIL rst_burst_in_ready got=%b exp=000", r_in_ready); else passed++;
        rq.delete();
        @(negedge clk);
        rst = 1'b0;
        rr_ptr = 2;
        r_in_data = {32'h4000_0002, 32'h4000_0001, 32'h4000_0000};
        r_in_last = 3'b111;
        r_in_valid = 3'b111;
        g = rr_pick(r_in_valid, rr_ptr);
        rq.push_back('{data: 32'h4000_0000 | 32'(g), last: 1'b1, chan: 2'(g)});
        #1;
        total++; if (r_in_ready !== (3'b001 << g)) $display("FAIL rst_burst_restart got=%b exp_chan=%0d", r_in_ready, g); else passed++;
        @(negedge clk);
        r_in_valid = '0;
        @(negedge clk);
        #1;
        total++; if (r_out_valid !== 1'b0) $display("FAIL rst_burst_drain got=%b exp=0", r_out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_fixed_single();
        test_fixed_bad_sel();
        test_back_to_back();
        test_rr_rotation();
        test_rr_burst();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        total++; if (fq.size() != 0) $display("FAIL fix_leftover got=%0d exp=0", fq.size()); else passed++;
        total++; if (rq.size() != 0) $display("FAIL rr_leftover got=%0d exp=0", rq.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
